lfsr_rand_gen: RTL and testbench

//   Parametrised Galois LFSR random-number source with runtime seeding and a

---
 rtl/lfsr_rand_gen.sv | 129 ++++++++++++
 tb/tb_lfsr_rand_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_gen.sv
// Galois LFSR random source with runtime seeding, three output ranges and a valid/ready handshake.
// Define LFSR_LEAP_EN to apply LEAP chained steps per clock instead of one.
module lfsr_rand_gen #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(8'h9C),
    parameter int               RANGE_N  = 40,
    parameter int               LEAP     = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [1:0]       mode_i,
    input  logic             rnd_ready,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_o,
    output logic             lockup_o
);

    localparam int RANGE_BITS = $clog2(RANGE_N);
    localparam int RB         = (RANGE_BITS < 1) ? 1 : RANGE_BITS;
    localparam logic [WIDTH-1:0] V_MASK = WIDTH'((64'd1 << RB) - 64'd1);

`ifdef LFSR_LEAP_EN
    localparam int STEPS = LEAP;
`else
    // LEAP has no effect here: exactly one step per clock.
    localparam int STEPS = 1 + 0 * LEAP;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_rnd;
    logic             r_valid;
    logic             r_lockup;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_v;
    logic [WIDTH-1:0] w_map;
    logic             w_accept;
    logic             w_run;
    logic             w_lock;
    logic             w_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (seed_load) w_fsm_next = RUN;
            RUN:     w_fsm_next = RUN;
            default: w_fsm_next = IDLE;
        endcase
    end

    // A zero state while running means the tap mask trapped us; recover instead of capturing.
    always_comb begin
        w_run  = (r_fsm == RUN);
        w_lock = w_run && !seed_load && (r_state == '0);
        w_cap  = w_run && !seed_load && (r_state != '0) && (!r_valid || rnd_ready);
    end

    always_comb begin
        w_next = r_state;
        for (int k = 0; k < STEPS; k++) begin
            w_next = (w_next >> 1) ^ (w_next[0] ? TAP_MASK : '0);
        end
    end

    always_comb begin
        w_map    = r_state;
        w_accept = 1'b1;
        w_v      = r_state & V_MASK;
        case (mode_i)
            2'd1:    w_map = {{(WIDTH-2){1'b0}}, r_state[1:0]};
            2'd2: begin
                w_map    = w_v + WIDTH'(1);
                w_accept = (64'(w_v) < 64'(RANGE_N));
            end
            default: w_map = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_rnd    <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_lock;

            if (seed_load) begin
                r_state <= (seed_i == '0) ? WIDTH'(1) : seed_i;
            end else if (w_lock) begin
                r_state <= WIDTH'(1);
            end else if (w_run) begin
                r_state <= w_next;
            end

            // A reseed flushes any pending sample; a rejected mapping leaves no sample.
            if (seed_load) begin
                r_valid <= 1'b0;
            end else if (w_lock) begin
                if (rnd_ready) r_valid <= 1'b0;
            end else if (w_cap) begin
                r_valid <= w_accept;
                if (w_accept) r_rnd <= w_map;
            end
        end
    end

    assign rnd_valid = r_valid;
    assign rnd_o     = r_rnd;
    assign lockup_o  = r_lockup;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed testbench for lfsr_rand_gen with hand-computed sequences for the default parameters,
// plus a second instance with a degenerate tap mask to exercise lock-up recovery.
module tb_lfsr_rand_gen;

    logic       clk;
    logic       rst_n;
    logic       seedLoad;
    logic [7:0] seedIn;
    logic [1:0] modeIn;
    logic       rndReady;

    logic       rndValid;
    logic [7:0] rndOut;
    logic       lockup;
    logic       badValid;
    logic [7:0] badOut;
    logic       badLockup;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] expRaw  [5] = '{8'h01, 8'h9C, 8'h4E, 8'h27, 8'h8F};
    logic [7:0] expMod1 [5] = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd3};
    logic [7:0] expMod2 [5] = '{8'd2, 8'd29, 8'd15, 8'd40, 8'd16};

    lfsr_rand_gen u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seedLoad),
        .seed_i    (seedIn),
        .mode_i    (modeIn),
        .rnd_ready (rndReady),
        .rnd_valid (rndValid),
        .rnd_o     (rndOut),
        .lockup_o  (lockup)
    );

    // Mask 0x40 sends 0x81 straight to zero, forcing the recovery path.
    lfsr_rand_gen #(.TAP_MASK(8'h40)) u_bad (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seedLoad),
        .seed_i    (seedIn),
        .mode_i    (modeIn),
        .rnd_ready (rndReady),
        .rnd_valid (badValid),
        .rnd_o     (badOut),
        .lockup_o  (badLockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic [7:0] seed,
                                 input logic [1:0] mode, input logic ready);
        seedLoad = load;
        seedIn   = seed;
        modeIn   = mode;
        rndReady = ready;
    endtask

    // Pulse seed_load for one clock; returns at the negedge after the loading edge.
    task automatic seedAndStart(input logic [7:0] seed, input logic [1:0] mode);
        applyStimulus(1'b1, seed, mode, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, seed, mode, 1'b1);
        checkOutput("flush_valid", {31'd0, rndValid}, 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {31'd0, rndValid}, 32'd0);
        checkOutput("rst_rnd", {24'd0, rndOut}, 32'd0);
        checkOutput("rst_lockup", {31'd0, lockup}, 32'd0);
        rst_n = 1'b1;

        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_valid", {31'd0, rndValid}, 32'd0);
            checkOutput("idle_rnd", {24'd0, rndOut}, 32'd0);
        end

        $display("[TB] raw / mode1 / mode2 sequences from seed 0x01");
        seedAndStart(8'h01, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("raw_seq", {24'd0, rndOut}, {24'd0, expRaw[i]});
            checkOutput("raw_valid", {31'd0, rndValid}, 32'd1);
        end
        seedAndStart(8'h01, 2'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("mod1_seq", {24'd0, rndOut}, {24'd0, expMod1[i]});
        end
        seedAndStart(8'h01, 2'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("mod2_seq", {24'd0, rndOut}, {24'd0, expMod2[i]});
        end

        $display("[TB] mode2 rejection from seed 0x3F");
        seedAndStart(8'h3F, 2'd2);
        @(negedge clk);
        checkOutput("reject_valid", {31'd0, rndValid}, 32'd0);
        @(negedge clk);
        checkOutput("accept_valid", {31'd0, rndValid}, 32'd1);
        checkOutput("accept_rnd", {24'd0, rndOut}, 32'd4);

        $display("[TB] zero seed");
        seedAndStart(8'h00, 2'd0);
        checkOutput("zseed_lockup0", {31'd0, lockup}, 32'd0);
        @(negedge clk);
        checkOutput("zseed_rnd0", {24'd0, rndOut}, 32'h01);
        checkOutput("zseed_lockup1", {31'd0, lockup}, 32'd0);
        @(negedge clk);
        checkOutput("zseed_rnd1", {24'd0, rndOut}, 32'h9C);
        checkOutput("zseed_lockup2", {31'd0, lockup}, 32'd0);

        $display("[TB] backpressure");
        seedAndStart(8'h01, 2'd0);
        @(negedge clk);
        checkOutput("bp_first", {24'd0, rndOut}, 32'h01);
        rndReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_rnd", {24'd0, rndOut}, 32'h01);
            checkOutput("bp_hold_valid", {31'd0, rndValid}, 32'd1);
        end
        rndReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", {24'd0, rndOut}, 32'hF1);
        @(negedge clk);
        checkOutput("bp_next", {24'd0, rndOut}, 32'hE4);

        $display("[TB] lock-up recovery");
        seedAndStart(8'h81, 2'd0);
        checkOutput("lk_n1_lockup", {31'd0, badLockup}, 32'd0);
        @(negedge clk);
        checkOutput("lk_n2_rnd", {24'd0, badOut}, 32'h81);
        checkOutput("lk_n2_valid", {31'd0, badValid}, 32'd1);
        checkOutput("lk_n2_lockup", {31'd0, badLockup}, 32'd0);
        @(negedge clk);
        checkOutput("lk_pulse", {31'd0, badLockup}, 32'd1);
        checkOutput("lk_nocap_valid", {31'd0, badValid}, 32'd0);
        checkOutput("lk_good_lockup", {31'd0, lockup}, 32'd0);
        @(negedge clk);
        checkOutput("lk_pulse_end", {31'd0, badLockup}, 32'd0);
        checkOutput("lk_recover_valid", {31'd0, badValid}, 32'd1);
        checkOutput("lk_recover_rnd", {24'd0, badOut}, 32'h01);

        $display("[TB] reset mid-stream");
        seedAndStart(8'h01, 2'd0);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_rnd", {24'd0, rndOut}, 32'h9C);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, rndValid}, 32'd0);
        checkOutput("async_rst_rnd", {24'd0, rndOut}, 32'd0);
        checkOutput("async_rst_lockup", {31'd0, lockup}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_valid", {31'd0, rndValid}, 32'd0);
            checkOutput("post_rst_rnd", {24'd0, rndOut}, 32'd0);
        end
        seedAndStart(8'h01, 2'd0);
        @(negedge clk);
        checkOutput("reseed_rnd", {24'd0, rndOut}, 32'h01);
        checkOutput("reseed_valid", {31'd0, rndValid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
